// File: rtl/count_seq_checker.sv
// Consumer-side checker for a free-running modulo-2^WIDTH up-count stream.
// Optional macro RESYNC_ZERO_EN: a 0 sample while locked is treated as an upstream reset.
//
// state   | meaning
// IDLE    | no reference value yet; expected reads 0
// ACQUIRE | counting consecutive correct increments toward LOCK_CNT
// LOCKED  | every sample must equal expected; breaks are counted
module count_seq_checker #(
  parameter int WIDTH     = 5,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 mismatch,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 resync_pulse
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           run_q, run_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 mismatch_q, mismatch_d;
  logic                 wrap_q, wrap_d;
  logic [WIDTH-1:0]     exp_next;
  logic [3:0]           run_inc;
`ifdef RESYNC_ZERO_EN
  logic                 resync_q, resync_d;
`endif

  assign exp_next = prev_q + WIDTH'(1);
  assign run_inc  = run_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
`ifdef RESYNC_ZERO_EN
    resync_d   = 1'b0;
`endif
    if (clear) begin
      state_d = IDLE;
      prev_d  = '0;
      run_d   = '0;
      err_d   = '0;
    end else if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          prev_d  = count_in;
          run_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          prev_d = count_in;
          if (count_in == exp_next) begin
            if (run_inc == LOCK_V) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (count_in == exp_next) begin
            prev_d = count_in;
            wrap_d = (count_in == '0);
`ifdef RESYNC_ZERO_EN
          end else if (count_in == '0) begin
            // upstream counter restarted; re-anchor without counting an error
            prev_d   = '0;
            resync_d = 1'b1;
`endif
          end else begin
            mismatch_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            prev_d  = count_in;
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
        default: begin
          state_d = IDLE;
          prev_d  = '0;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef RESYNC_ZERO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) resync_q <= 1'b0;
    else          resync_q <= resync_d;
  end
  assign resync_pulse = resync_q;
`else
  assign resync_pulse = 1'b0;
`endif

  assign locked     = (state_q == LOCKED);
  assign expected   = (state_q == IDLE) ? '0 : exp_next;
  assign mismatch   = mismatch_q;
  assign wrap_pulse = wrap_q;
  assign err_count  = err_q;

endmodule
